// File: rtl/iris_mlp_pkg.sv
// rtl/iris_mlp_pkg.sv - shared widths, state encoding, weights and biases for the Iris MLP sequencer
package iris_mlp_pkg;

    localparam int FEAT_W = 4;    // unsigned input feature width
    localparam int HID_W  = 14;   // unsigned post-ReLU hidden value width
    localparam int ACC_W  = 24;   // signed accumulator width
    localparam int N_IN   = 4;
    localparam int N_HID  = 3;
    localparam int N_OUT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L0   = 2'd1,
        ST_L1   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic signed [7:0]       weight_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Layer 0: W0[hidden neuron][input feature]
    localparam weight_t W0 [N_HID][N_IN] = '{
        '{-8'sd29,  8'sd48, -8'sd62, -8'sd57},
        '{ 8'sd0,  -8'sd7,   8'sd5,   8'sd18},
        '{-8'sd15, -8'sd1,   8'sd108, 8'sd31}
    };

    localparam acc_t BIAS0 [N_HID] = '{24'sd639, -24'sd698, -24'sd1112};

    // Layer 1: W1[output neuron][hidden neuron]
    localparam weight_t W1 [N_OUT][N_HID] = '{
        '{ 8'sd71,  8'sd30, -8'sd105},
        '{-8'sd69, -8'sd13, -8'sd75},
        '{-8'sd55, -8'sd42,  8'sd75}
    };

    localparam acc_t BIAS1 [N_OUT] = '{-24'sd11255, 24'sd17487, -24'sd17315};

    // Negative sums clamp to zero; otherwise the sum passes through unchanged.
    function automatic acc_t relu(input acc_t v);
        return v[ACC_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/iris_mac.sv
// rtl/iris_mac.sv - combinational shared multiply-accumulate step with weight lookup and ReLU
//
// Ports:
//   layer    - 0 selects layer 0 (features, W0/BIAS0), 1 selects layer 1 (hidden, W1/BIAS1)
//   n        - neuron index within the selected layer
//   t        - term index; t==0 starts a fresh sum from the neuron bias
//   feat     - latched feature vector, x_t = feat[t*FEAT_W +: FEAT_W]
//   hid      - hidden layer values h[0..2]
//   acc      - running accumulator from the previous term
//   acc_next - (t==0 ? bias : acc) + weight * operand
//   act      - ReLU of acc_next
module iris_mac
    import iris_mlp_pkg::*;
(
    input  logic                        layer,
    input  logic [1:0]                  n,
    input  logic [1:0]                  t,
    input  logic [N_IN*FEAT_W-1:0]      feat,
    input  logic [N_HID-1:0][HID_W-1:0] hid,
    input  acc_t                        acc,
    output acc_t                        acc_next,
    output acc_t                        act
);

    weight_t w;
    acc_t    bias;
    acc_t    opnd;
    acc_t    prod;
    acc_t    base;

    always_comb begin
        w    = '0;
        bias = '0;
        opnd = '0;
        if (!layer) begin
            if (n < 2'd3) begin
                w    = W0[n][t];
                bias = BIAS0[n];
            end
            opnd = acc_t'({{(ACC_W-FEAT_W){1'b0}}, feat[t*FEAT_W +: FEAT_W]});
        end else begin
            // Layer 1 has only three terms; out-of-range indices contribute nothing.
            if (n < 2'd3 && t < 2'd3) begin
                w    = W1[n][t];
                bias = BIAS1[n];
                opnd = acc_t'({{(ACC_W-HID_W){1'b0}}, hid[t]});
            end
        end
    end

    // Weight is sign-extended, operand zero-extended, so the product is signed x unsigned.
    assign prod     = acc_t'(w) * opnd;
    assign base     = (t == 2'd0) ? bias : acc;
    assign acc_next = base + prod;
    assign act      = relu(acc_next);

endmodule

// File: rtl/iris_mlp_seq.sv
// rtl/iris_mlp_seq.sv - time-multiplexed 4-3-3 Iris MLP classifier, one MAC per cycle
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready/inp - feature vector handshake, x_i = inp[4i+3:4i]
//   out_valid/out_ready/out - class index handshake, out in 0..2
//   busy                 - high while layers L0/L1 are being evaluated
module iris_mlp_seq
    import iris_mlp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] inp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out,
    output logic        busy
);

    state_t                      state;
    logic [N_IN*FEAT_W-1:0]      feat_q;
    logic [1:0]                  n_q;
    logic [1:0]                  t_q;
    acc_t                        acc_q;
    logic [N_HID-1:0][HID_W-1:0] h_q;
    acc_t                        best_val;
    logic [1:0]                  best_idx;
    logic                        in_ready_q;

    acc_t mac_acc_next;
    acc_t mac_act;
    logic last_term;
    logic new_best;
    logic accept;

    // Registered IDLE term, plus a combinational DONE term so a waiting result
    // can be drained and a new vector taken in the same cycle.
    assign in_ready  = in_ready_q || (state == ST_DONE && out_ready);
    assign accept    = in_valid && in_ready;

    // L0 neurons sum four features, L1 neurons sum three hidden values.
    assign last_term = (state == ST_L0) ? (t_q == 2'd3) : (t_q == 2'd2);

    // Strict comparison keeps the lower index on ties; neuron 0 always loads.
    assign new_best  = (n_q == 2'd0) || (mac_act > best_val);

    iris_mac u_mac (
        .layer    (state == ST_L1),
        .n        (n_q),
        .t        (t_q),
        .feat     (feat_q),
        .hid      (h_q),
        .acc      (acc_q),
        .acc_next (mac_acc_next),
        .act      (mac_act)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready_q <= 1'b1;
            out_valid  <= 1'b0;
            out        <= 2'd0;
            busy       <= 1'b0;
            feat_q     <= '0;
            n_q        <= 2'd0;
            t_q        <= 2'd0;
            acc_q      <= '0;
            h_q        <= '0;
            best_val   <= '0;
            best_idx   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        feat_q     <= inp;
                        n_q        <= 2'd0;
                        t_q        <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_L0;
                    end
                end

                ST_L0: begin
                    acc_q <= mac_acc_next;
                    if (last_term) begin
                        h_q[n_q] <= mac_act[HID_W-1:0];
                        t_q      <= 2'd0;
                        if (n_q == 2'd2) begin
                            n_q   <= 2'd0;
                            state <= ST_L1;
                        end else begin
                            n_q <= n_q + 2'd1;
                        end
                    end else begin
                        t_q <= t_q + 2'd1;
                    end
                end

                ST_L1: begin
                    acc_q <= mac_acc_next;
                    if (last_term) begin
                        if (new_best) begin
                            best_val <= mac_act;
                            best_idx <= n_q;
                        end
                        t_q <= 2'd0;
                        if (n_q == 2'd2) begin
                            // Fold in the last neuron's comparison directly, since
                            // best_idx only updates on this same edge.
                            n_q       <= 2'd0;
                            out       <= new_best ? n_q : best_idx;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            n_q <= n_q + 2'd1;
                        end
                    end else begin
                        t_q <= t_q + 2'd1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            feat_q <= inp;
                            n_q    <= 2'd0;
                            t_q    <= 2'd0;
                            busy   <= 1'b1;
                            state  <= ST_L0;
                        end else begin
                            in_ready_q <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
